// File: rtl/isa_pkg.sv
// Shared ISA definitions for the program sequencer:
// opcodes, register codes, field slices, write-source codes and FSM states.
package isa_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_MUL = 4'h2;
  localparam logic [3:0] OP_DIV = 4'h3;
  localparam logic [3:0] OP_SHL = 4'h4;
  localparam logic [3:0] OP_SHR = 4'h5;
  localparam logic [3:0] OP_SQA = 4'h6;
  localparam logic [3:0] OP_SQB = 4'h7;
  localparam logic [3:0] OP_MOV = 4'h8;
  localparam logic [3:0] OP_LDA = 4'h9;
  localparam logic [3:0] OP_LDB = 4'hA;
  localparam logic [3:0] OP_OUT = 4'hB;

  localparam logic [1:0] R0 = 2'd0;
  localparam logic [1:0] R1 = 2'd1;
  localparam logic [1:0] R2 = 2'd2;
  localparam logic [1:0] R3 = 2'd3;

  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 4;
  localparam int RD_MSB  = 3;
  localparam int RD_LSB  = 2;
  localparam int RB_MSB  = 1;
  localparam int RB_LSB  = 0;

  localparam logic [1:0] WSEL_ALU = 2'd0;
  localparam logic [1:0] WSEL_A   = 2'd1;
  localparam logic [1:0] WSEL_B   = 2'd2;
  localparam logic [1:0] WSEL_MOV = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    OUT_WAIT,
    DONE
  } state_e;

  typedef struct packed {
    logic [3:0] alu_op;
    logic [1:0] wsel;
    logic       writes;
    logic       is_muldiv;
    logic       is_out;
    logic       illegal;
  } dec_t;

  function automatic logic [3:0] opc_of(input logic [7:0] ir);
    return ir[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [1:0] rd_of(input logic [7:0] ir);
    return ir[RD_MSB:RD_LSB];
  endfunction

  function automatic logic [1:0] rb_of(input logic [7:0] ir);
    return ir[RB_MSB:RB_LSB];
  endfunction

endpackage

// File: rtl/prog_sequencer_if.sv
// ROM, register-file/ALU control and out-handshake bundle
// between the sequencer (master) and the datapath side (slave).
interface prog_sequencer_if;

  logic [1:0] rom_prog;
  logic [7:0] rom_addr;
  logic [7:0] rom_instr;
  logic [3:0] alu_op;
  logic [1:0] rf_raddr_a;
  logic [1:0] rf_raddr_b;
  logic       rf_we;
  logic [1:0] rf_waddr;
  logic [1:0] rf_wsel;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output rom_prog,
    output rom_addr,
    input  rom_instr,
    output alu_op,
    output rf_raddr_a,
    output rf_raddr_b,
    output rf_we,
    output rf_waddr,
    output rf_wsel,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  rom_prog,
    input  rom_addr,
    output rom_instr,
    input  alu_op,
    input  rf_raddr_a,
    input  rf_raddr_b,
    input  rf_we,
    input  rf_waddr,
    input  rf_wsel,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/instr_decode.sv
// Combinational instruction decoder: IR to ALU opcode,
// write source and instruction class flags.
module instr_decode
  import isa_pkg::*;
(
  input  logic [7:0] ir_i,
  output dec_t       dec_o
);

  logic [3:0] op;

  assign op = opc_of(ir_i);

  always_comb begin
    dec_o = '0;
    unique case (1'b1)
      (op[3] == 1'b0): begin
        dec_o.alu_op    = op;
        dec_o.wsel      = WSEL_ALU;
        dec_o.writes    = 1'b1;
        dec_o.is_muldiv = (op == OP_MUL) || (op == OP_DIV);
      end
      (op == OP_MOV): begin
        dec_o.wsel   = WSEL_MOV;
        dec_o.writes = 1'b1;
      end
      (op == OP_LDA): begin
        dec_o.wsel   = WSEL_A;
        dec_o.writes = 1'b1;
      end
      (op == OP_LDB): begin
        dec_o.wsel   = WSEL_B;
        dec_o.writes = 1'b1;
      end
      (op == OP_OUT): begin
        dec_o.is_out = 1'b1;
      end
      default: begin
        dec_o.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/prog_sequencer.sv
// Fetch/decode/control unit: drives the ROM, holds PC and IR,
// and steps the register file and ALU through each instruction.
module prog_sequencer
  import isa_pkg::*;
#(
  parameter int unsigned MULDIV_CYCLES = 3,
  parameter logic [7:0]  MAX_ADDR      = 8'd31
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       prog_sel,
  prog_sequencer_if.master bus,
  output logic             busy,
  output logic             done,
  output logic             fault
);

  localparam logic [7:0] CNT_LOAD = 8'(MULDIV_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [1:0] prog_q, prog_d;
  logic [7:0] cnt_q, cnt_d;
  logic       fault_q, fault_d;

  dec_t       dec;
  logic       rf_we;
  logic [1:0] rf_wsel;
  logic       out_valid;
  logic       last;

  instr_decode u_dec (
    .ir_i  (ir_q),
    .dec_o (dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      prog_q  <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      prog_q  <= prog_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    prog_d    = prog_q;
    cnt_d     = cnt_q;
    fault_d   = fault_q;
    rf_we     = 1'b0;
    rf_wsel   = WSEL_ALU;
    out_valid = 1'b0;
    last      = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          prog_d  = prog_sel;
          pc_d    = '0;
          fault_d = 1'b0;
          state_d = FETCH;
        end
      end

      FETCH: begin
        if (pc_q > MAX_ADDR) begin
          fault_d = 1'b1;
          state_d = DONE;
        end else begin
          ir_d    = bus.rom_instr;
          cnt_d   = CNT_LOAD;
          state_d = EXEC;
        end
      end

      EXEC: begin
        rf_wsel = dec.wsel;
        unique case (1'b1)
          dec.illegal: begin
            fault_d = 1'b1;
            state_d = DONE;
          end
          // out presents its value from the first EXEC cycle on
          dec.is_out: begin
            out_valid = 1'b1;
            state_d   = bus.out_ready ? DONE : OUT_WAIT;
          end
          dec.writes: begin
            last = !dec.is_muldiv || (cnt_q == 8'd0);
            if (last) begin
              rf_we   = 1'b1;
              pc_d    = pc_q + 8'd1;
              state_d = FETCH;
            end else begin
              cnt_d = cnt_q - 8'd1;
            end
          end
          default: ;
        endcase
      end

      OUT_WAIT: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = DONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.rom_prog   = prog_q;
  assign bus.rom_addr   = pc_q;
  assign bus.alu_op     = dec.alu_op;
  assign bus.rf_raddr_a = rd_of(ir_q);
  assign bus.rf_raddr_b = rb_of(ir_q);
  assign bus.rf_waddr   = rd_of(ir_q);
  assign bus.rf_we      = rf_we;
  assign bus.rf_wsel    = rf_wsel;
  assign bus.out_valid  = out_valid;

  assign busy  = (state_q == FETCH) || (state_q == EXEC) ||
                 (state_q == OUT_WAIT);
  assign done  = (state_q == DONE);
  assign fault = fault_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Randomized bench for prog_sequencer: an instruction-level model
// expands each program into an expected per-cycle output timeline.
module tb_prog_sequencer;
  import isa_pkg::*;

  localparam int unsigned MDC  = 3;
  localparam logic [7:0]  MAXA = 8'd31;

  typedef struct {
    logic [7:0] addr;
    logic [1:0] prog;
    logic       busy;
    logic       done;
    logic       fault;
    logic       valid;
    logic       we;
    logic [1:0] wsel;
    logic [1:0] ra;
    logic [1:0] rb;
    logic       chk_alu;
    logic [3:0] alu;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] prog_sel;
  logic       out_ready;
  logic       busy, done, fault;

  logic [7:0] rom [4][256];

  int   checks = 0;
  int   errors = 0;
  rec_t exp_q[$];
  rec_t idle_rec;
  bit   rdy [1024];
  logic [7:0] m_pc, m_ir;
  logic [1:0] m_prog;
  logic       m_fault;

  always #5 clk = ~clk;

  prog_sequencer_if bus ();

  assign bus.rom_instr = rom[bus.rom_prog][bus.rom_addr];
  assign bus.out_ready = out_ready;

  prog_sequencer #(
    .MULDIV_CYCLES (MDC),
    .MAX_ADDR      (MAXA)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .prog_sel (prog_sel),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .fault    (fault)
  );

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, req,
               $time);
    end
  endtask

  function automatic logic [1:0] wsel_of(input logic [3:0] op);
    case (op)
      OP_MOV:  return 2'd3;
      OP_LDA:  return 2'd1;
      OP_LDB:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  function automatic bit rdy_at(input int k);
    return (k < 1024) ? rdy[k] : 1'b1;
  endfunction

  function automatic rec_t mk(input logic b);
    rec_t r;
    r.addr    = m_pc;
    r.prog    = m_prog;
    r.busy    = b;
    r.done    = 1'b0;
    r.fault   = 1'b0;
    r.valid   = 1'b0;
    r.we      = 1'b0;
    r.wsel    = 2'd0;
    r.ra      = m_ir[3:2];
    r.rb      = m_ir[1:0];
    r.chk_alu = 1'b0;
    r.alu     = 4'd0;
    return r;
  endfunction

  // Walks the program instruction by instruction; each entry of
  // exp_q is one cycle after the start edge (entry k = cycle k+1).
  task automatic build(input int p);
    int         n;
    logic [3:0] op;
    rec_t       r;
    exp_q.delete();
    m_prog  = 2'(p);
    m_pc    = 8'd0;
    m_fault = 1'b0;
    forever begin
      exp_q.push_back(mk(1'b1));
      if (m_pc > MAXA) begin
        m_fault = 1'b1;
        break;
      end
      m_ir = rom[p][m_pc];
      op   = m_ir[7:4];
      if (op >= 4'd12) begin
        exp_q.push_back(mk(1'b1));
        m_fault = 1'b1;
        break;
      end
      if (op == OP_OUT) begin
        do begin
          r = mk(1'b1);
          r.valid = 1'b1;
          exp_q.push_back(r);
        end while (!rdy_at(exp_q.size() - 1));
        break;
      end
      n = (op == OP_MUL || op == OP_DIV) ? int'(MDC) : 1;
      for (int i = 0; i < n; i++) begin
        r = mk(1'b1);
        r.chk_alu = (op < 4'd8);
        r.alu     = op;
        if (i == n - 1) begin
          r.we   = 1'b1;
          r.wsel = wsel_of(op);
        end
        exp_q.push_back(r);
      end
      m_pc = m_pc + 8'd1;
    end
    idle_rec       = mk(1'b0);
    idle_rec.done  = 1'b1;
    idle_rec.fault = m_fault;
  endtask

  task automatic check(input rec_t e);
    chk("rom_addr", bus.rom_addr, e.addr);
    chk("rom_prog", 8'(bus.rom_prog), 8'(e.prog));
    chk("busy", 8'(busy), 8'(e.busy));
    chk("done", 8'(done), 8'(e.done));
    chk("fault", 8'(fault), 8'(e.fault));
    chk("out_valid", 8'(bus.out_valid), 8'(e.valid));
    chk("rf_we", 8'(bus.rf_we), 8'(e.we));
    chk("rf_raddr_a", 8'(bus.rf_raddr_a), 8'(e.ra));
    chk("rf_raddr_b", 8'(bus.rf_raddr_b), 8'(e.rb));
    if (e.we) begin
      chk("rf_wsel", 8'(bus.rf_wsel), 8'(e.wsel));
      chk("rf_waddr", 8'(bus.rf_waddr), 8'(e.ra));
    end
    if (e.chk_alu) chk("alu_op", 8'(bus.alu_op), 8'(e.alu));
  endtask

  task automatic cyc(input rec_t e, input logic s, input logic [1:0] ps,
                     input logic r);
    @(negedge clk);
    check(e);
    start     = s;
    prog_sel  = ps;
    out_ready = r;
  endtask

  task automatic run(input int p);
    cyc(idle_rec, 1'b1, 2'(p), 1'b0);
    build(p);
    for (int k = 0; k < exp_q.size(); k++)
      cyc(exp_q[k], 1'($urandom), 2'($urandom), rdy_at(k));
    repeat ($urandom_range(1, 3))
      cyc(idle_rec, 1'b0, 2'($urandom), 1'($urandom));
  endtask

  task automatic all_ready();
    for (int i = 0; i < 1024; i++) rdy[i] = 1'b1;
  endtask

  task automatic pin_prog0();
    int we_cyc[$];
    int ws[$];
    int first_v;
    first_v = -1;
    foreach (exp_q[k]) begin
      if (exp_q[k].we) begin
        we_cyc.push_back(k + 1);
        ws.push_back(int'(exp_q[k].wsel));
      end
      if (exp_q[k].valid && first_v < 0) first_v = k + 1;
    end
    chk("pin_we_count", 8'(we_cyc.size()), 8'd4);
    if (we_cyc.size() == 4) begin
      chk("pin_we_c0", 8'(we_cyc[0]), 8'd2);
      chk("pin_we_c1", 8'(we_cyc[1]), 8'd4);
      chk("pin_we_c2", 8'(we_cyc[2]), 8'd8);
      chk("pin_we_c3", 8'(we_cyc[3]), 8'd10);
      chk("pin_ws0", 8'(ws[0]), 8'd1);
      chk("pin_ws1", 8'(ws[1]), 8'd2);
      chk("pin_ws2", 8'(ws[2]), 8'd0);
      chk("pin_ws3", 8'(ws[3]), 8'd0);
    end
    chk("pin_valid_cycle", 8'(first_v), 8'd12);
  endtask

  task automatic rand_prog1();
    int pos;
    for (int a = 0; a < 256; a++) rom[1][a] = 8'h00;
    for (int a = 0; a < 32; a++)
      rom[1][a] = {4'($urandom_range(0, 10)), 4'($urandom)};
    pos = $urandom_range(0, 10);
    rom[1][pos] = {OP_OUT, 4'($urandom)};
    if ($urandom_range(0, 3) == 0)
      rom[1][$urandom_range(0, pos)] = {2'b11, 6'($urandom)};
    for (int i = 0; i < 1024; i++) rdy[i] = ($urandom_range(0, 2) != 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    prog_sel  = 2'd0;
    out_ready = 1'b0;
    for (int p = 0; p < 4; p++)
      for (int a = 0; a < 256; a++) rom[p][a] = 8'h00;
    rom[0][0] = 8'h90;
    rom[0][1] = 8'hA4;
    rom[0][2] = 8'h21;
    rom[0][3] = 8'h40;
    rom[0][4] = 8'hB0;
    rom[2][0] = 8'hC0;
    for (int a = 0; a < 32; a++)
      rom[3][a] = {4'($urandom_range(0, 10)), 4'($urandom)};

    #12;
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_done", 8'(done), 8'd0);
    chk("rst_fault", 8'(fault), 8'd0);
    chk("rst_we", 8'(bus.rf_we), 8'd0);
    chk("rst_valid", 8'(bus.out_valid), 8'd0);
    chk("rst_wsel", 8'(bus.rf_wsel), 8'd0);
    chk("rst_addr", bus.rom_addr, 8'd0);
    m_pc = 8'd0; m_ir = 8'd0; m_prog = 2'd0; m_fault = 1'b0;
    idle_rec = mk(1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    all_ready();
    run(0);
    pin_prog0();
    chk("pin_done_cycle", 8'(exp_q.size() + 1), 8'd13);

    for (int i = 11; i < 16; i++) rdy[i] = 1'b0;
    run(0);
    chk("pin_hold_done_cycle", 8'(exp_q.size() + 1), 8'd18);
    all_ready();

    run(2);
    chk("pin_illegal_done_cycle", 8'(exp_q.size() + 1), 8'd3);
    chk("pin_illegal_fault", 8'(idle_rec.fault), 8'd1);

    run(0);
    chk("pin_fault_cleared", 8'(idle_rec.fault), 8'd0);

    run(3);
    chk("pin_maxaddr_pc", idle_rec.addr, 8'd32);
    chk("pin_maxaddr_fault", 8'(idle_rec.fault), 8'd1);

    for (int t = 0; t < 25; t++) begin
      rand_prog1();
      run(1);
    end

    all_ready();
    cyc(idle_rec, 1'b1, 2'd0, 1'b1);
    build(0);
    for (int k = 0; k < 6; k++) cyc(exp_q[k], 1'b0, 2'd0, 1'b1);
    @(negedge clk);
    check(exp_q[6]);
    chk("pre_rst_addr", bus.rom_addr, 8'd2);
    rst_n = 1'b0;
    #1;
    chk("arst_we", 8'(bus.rf_we), 8'd0);
    chk("arst_busy", 8'(busy), 8'd0);
    chk("arst_done", 8'(done), 8'd0);
    chk("arst_fault", 8'(fault), 8'd0);
    chk("arst_valid", 8'(bus.out_valid), 8'd0);
    chk("arst_addr", bus.rom_addr, 8'd0);
    chk("arst_wsel", 8'(bus.rf_wsel), 8'd0);
    m_pc = 8'd0; m_ir = 8'd0; m_prog = 2'd0; m_fault = 1'b0;
    idle_rec = mk(1'b0);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (3) cyc(idle_rec, 1'b0, 2'($urandom), 1'b1);
    run(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
- Fetch/decode/control unit on the reading side of the 8-bit instruction ROM.
- Selects the program, drives the ROM address, latches each returned instruction into an instruction register, and decodes it.
- Sequences the 4-entry register file and ALU through each instruction, and presents `out` results via a valid/ready handshake.
- Sits between the ROM, the register file/ALU datapath and the board output logic.

Parameters:
- MULDIV_CYCLES, 3: EXEC cycles for mul/div (opcodes 0010/0011); minimum 1.
- MAX_ADDR, 8'd31: last legal PC; fetching beyond it raises fault.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a run; sampled only in IDLE or DONE
- prog_sel  in  2  program number, latched on accepted start
- rom_prog  out  2  program select to ROM (latched copy)
- rom_addr  out  8  ROM address (= PC register)
- rom_instr  in  8  ROM data, combinational from rom_prog/rom_addr
- alu_op  out  4  ALU opcode (= IR[7:4] for opcodes 0000-0111)
- rf_raddr_a  out  2  read port A = IR[3:2]
- rf_raddr_b  out  2  read port B = IR[1:0]
- rf_we  out  1  register-file write strobe
- rf_waddr  out  2  write address = IR[3:2]
- rf_wsel  out  2  write source: 0 ALU result, 1 data_a switches, 2 data_b switches, 3 read port B (mov)
- out_valid  out  1  port A holds an `out` value
- out_ready  in  1  consumer accepts the `out` value
- busy  out  1  high in FETCH/EXEC/OUT_WAIT
- done  out  1  high in DONE
- fault  out  1  sticky error flag, cleared on next accepted start

Behaviour:
- Instruction format: [7:4] opcode, [3:2] rd/ra, [1:0] rb.
- Opcodes: 0000 add, 0001 sub, 0010 mul, 0011 div, 0100 shl, 0101 shr, 0110 sqa, 0111 sqb, 1000 mov, 1001 lda, 1010 ldb, 1011 out. Opcodes 1100-1111 are illegal.
- Reset (async, rst_n=0):
  - State IDLE; PC=0; IR=0; rom_prog=0.
  - All strobes (rf_we, out_valid, busy, done, fault) = 0; rf_wsel=0.
  - Reset mid-run aborts immediately; no write completes after rst_n falls.
- IDLE / DONE: start=1 latches prog_sel into rom_prog, sets PC=0, clears fault, goes to FETCH. In DONE, start=0 holds DONE.
- FETCH (1 cycle): rom_addr=PC is stable. At the clock edge, IR <= rom_instr and state goes to EXEC.
  - If PC > MAX_ADDR, go to DONE with fault=1 instead.
- EXEC:
  - Opcodes 0000-0111: alu_op=IR[7:4], rf_wsel=0.
  - mov: rf_wsel=3.
  - lda: rf_wsel=1.
  - ldb: rf_wsel=2.
  - Duration: 1 cycle, or MULDIV_CYCLES cycles for mul/div. A down-counter is loaded on FETCH→EXEC.
  - rf_we=1 only in the final EXEC cycle, for exactly one cycle. On that edge PC <= PC+1 (8-bit; MAX_ADDR check prevents wrap) and state goes to FETCH.
  - out: no write; go to OUT_WAIT.
  - Illegal opcode: no write; go to DONE with fault=1.
- OUT_WAIT: out_valid=1 with rf_raddr_a=IR[3:2] held constant.
  - Transfer occurs on a cycle with out_valid && out_ready; then go to DONE (out terminates the program).
  - out_ready already high on entry: transfer completes in 1 cycle.
- Changes on prog_sel or start while busy are ignored.
- rf_raddr_a/b always reflect IR, including outside EXEC.
- One instruction takes 2 cycles, or 1+MULDIV_CYCLES for mul/div.

Decomposition:
- Shared package `isa_pkg`:
  - opcode constants (OP_ADD…OP_OUT)
  - register codes R0-R3
  - field-slice localparams (OPC_MSB=7, RD_LSB=2)
  - rf_wsel encodings
  - state enum {IDLE, FETCH, EXEC, OUT_WAIT, DONE}
- One sub-module, `instr_decode`: combinational IR → {alu_op, rf_wsel, writes, is_muldiv, is_out, illegal}.
- The FSM, PC, IR and counter stay in prog_sequencer.

Test Plan:
- Program 00 (lda r0; ldb r1; mul r0,r1; shl r0; out r0), MULDIV_CYCLES=3, out_ready=1, start at cycle 0:
  - rf_we pulses at cycles 2, 4, 8, 10 with rf_wsel 1, 2, 0, 0.
  - out_valid at cycle 12 with rf_raddr_a=0; done at cycle 13.
- Same run with out_ready held 0 for 5 cycles: out_valid stays high, rf_raddr_a stable, PC not advanced; DONE one cycle after out_ready=1.
- ROM model returning 8'hC0 at address 0: no rf_we; fault=1 and done=1 at cycle 3. A new start clears fault.
- ROM model with no `out` (all lda) and MAX_ADDR=3: four writes, then fault=1 at the fetch of PC=4.
- rst_n low during the 2nd mul EXEC cycle: all outputs 0 immediately and PC=0; with rst_n released and start=0, the block stays in IDLE.
- prog_sel changed from 01 to 10 while busy: rom_prog stays 01 for the whole run.
